// File: rtl/mole_light_sequencer.sv
// Whack-a-mole light sequencer: pseudo-random light selection, hit/miss/wrong detection, saturating scores.
// Optional macro MOLE_NO_REPEAT_EN: never light the same index twice in a row.
module mole_light_sequencer #(
    parameter int NUM_LIGHTS = 9,
    parameter int TIME_W     = 28,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_seed,
    input  logic [15:0]           seed,
    input  logic [TIME_W-1:0]     on_time,
    input  logic [TIME_W-1:0]     gap_time,
    input  logic [NUM_LIGHTS-1:0] hit_btn,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [3:0]            active_idx,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  wrong_pulse,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_ON   = 2'd2
    } state_t;

    localparam logic [15:0]       NL16     = 16'(NUM_LIGHTS);
    localparam logic [TIME_W-1:0] T_ONE    = TIME_W'(1);
    localparam logic [NUM_LIGHTS-1:0] ONE_HOT0 = NUM_LIGHTS'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t                r_state, w_state_nxt;
    logic [TIME_W-1:0]     r_timer, w_timer_nxt;
    logic [15:0]           r_lfsr, w_lfsr_nxt;
    logic [NUM_LIGHTS-1:0] r_btn_q;
    logic [NUM_LIGHTS-1:0] r_lights, w_lights_nxt;
    logic [3:0]            r_idx, w_idx_nxt;
    logic                  r_hit, w_hit_nxt;
    logic                  r_miss, w_miss_nxt;
    logic                  r_wrong, w_wrong_nxt;
    logic [CNT_W-1:0]      r_hit_cnt, w_hit_cnt_nxt;
    logic [CNT_W-1:0]      r_miss_cnt, w_miss_cnt_nxt;

    logic [NUM_LIGHTS-1:0] w_press;
    logic                  w_hit_evt;
    logic                  w_wrong_evt;
    logic [TIME_W-1:0]     w_gap_len;
    logic [TIME_W-1:0]     w_on_len;
    logic                  w_fb;
    logic [3:0]            w_sel_raw;
    logic [3:0]            w_sel;
    logic [NUM_LIGHTS-1:0] w_sel_mask;

    // While ON, r_lights is exactly the one-hot mask of the lit index.
    assign w_press     = hit_btn & ~r_btn_q;
    assign w_hit_evt   = |(w_press & r_lights);
    assign w_wrong_evt = |(w_press & ~r_lights);
    assign w_gap_len   = (gap_time == '0) ? T_ONE : gap_time;
    assign w_on_len    = (on_time == '0) ? T_ONE : on_time;
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_sel_raw   = 4'(r_lfsr % NL16);

`ifdef MOLE_NO_REPEAT_EN
    localparam logic [4:0] PREV_NONE = 5'(NUM_LIGHTS);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_LIGHTS - 1);
    logic [4:0] r_prev, w_prev_nxt;

    assign w_sel = ({1'b0, w_sel_raw} == r_prev)
                 ? ((w_sel_raw == LAST_IDX) ? 4'd0 : w_sel_raw + 4'd1)
                 : w_sel_raw;
`else
    assign w_sel = w_sel_raw;
`endif

    assign w_sel_mask = ONE_HOT0 << w_sel;
    assign w_lfsr_nxt = load_seed ? ((seed == 16'h0000) ? 16'h0001 : seed)
                                  : {r_lfsr[14:0], w_fb};

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_lights_nxt   = r_lights;
        w_idx_nxt      = r_idx;
        w_hit_nxt      = 1'b0;
        w_miss_nxt     = 1'b0;
        w_wrong_nxt    = 1'b0;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
`ifdef MOLE_NO_REPEAT_EN
        w_prev_nxt     = r_prev;
`endif
        if (!enable) begin
            w_state_nxt  = S_IDLE;
            w_lights_nxt = '0;
            w_idx_nxt    = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt  = S_GAP;
                    w_timer_nxt  = w_gap_len;
                    w_lights_nxt = '0;
                    w_idx_nxt    = 4'd0;
                end
                S_GAP: begin
                    if (r_timer <= T_ONE) begin
                        w_state_nxt  = S_ON;
                        w_timer_nxt  = w_on_len;
                        w_lights_nxt = w_sel_mask;
                        w_idx_nxt    = w_sel;
`ifdef MOLE_NO_REPEAT_EN
                        w_prev_nxt   = {1'b0, w_sel};
`endif
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                S_ON: begin
                    w_wrong_nxt = w_wrong_evt;
                    // A hit on the final ON cycle takes precedence over the timeout.
                    if (w_hit_evt || (r_timer <= T_ONE)) begin
                        w_state_nxt  = S_GAP;
                        w_timer_nxt  = w_gap_len;
                        w_lights_nxt = '0;
                        w_idx_nxt    = 4'd0;
                        if (w_hit_evt) begin
                            w_hit_nxt     = 1'b1;
                            w_hit_cnt_nxt = sat_inc(r_hit_cnt);
                        end else begin
                            w_miss_nxt     = 1'b1;
                            w_miss_cnt_nxt = sat_inc(r_miss_cnt);
                        end
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_lights_nxt = '0;
                    w_idx_nxt    = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_lfsr     <= 16'h0001;
            r_btn_q    <= '0;
            r_lights   <= '0;
            r_idx      <= 4'd0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_wrong    <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_btn_q    <= hit_btn;
            r_lights   <= w_lights_nxt;
            r_idx      <= w_idx_nxt;
            r_hit      <= w_hit_nxt;
            r_miss     <= w_miss_nxt;
            r_wrong    <= w_wrong_nxt;
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

`ifdef MOLE_NO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= PREV_NONE;
        end else begin
            r_prev <= w_prev_nxt;
        end
    end
`endif

    assign lights      = r_lights;
    assign active_idx  = r_idx;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign wrong_pulse = r_wrong;
    assign hit_count   = r_hit_cnt;
    assign miss_count  = r_miss_cnt;

endmodule
